// File: rtl/cnn_layer_accel_weight_seq_pkg.sv
// Shared constants and helpers for the weight sequence table sequencer.
package cnn_layer_accel_weight_seq_pkg;

   // Default number of table entries issued per column.
   localparam int SEQ_LEN_DEF = 5;

   // Width of the table entry index bus.
   localparam int ADDR_W = 3;

   // Sequencer states. Kept as plain 2-bit constants so older RTL can share the encoding.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Next value in the 2-bit Gray cycle 00 -> 01 -> 11 -> 10 -> 00.
   function automatic logic [1:0] gray2_next(input logic [1:0] g);
      logic [1:0] n;
      case (g)
         2'b00:   n = 2'b01;
         2'b01:   n = 2'b11;
         2'b11:   n = 2'b10;
         default: n = 2'b00;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/cnn_layer_accel_gray_cnt2.sv
// 2-bit Gray-code counter with synchronous clear and count enable.
module cnn_layer_accel_gray_cnt2
   import cnn_layer_accel_weight_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       en_i,
   output logic [1:0] gray_o
);

   logic [1:0] gray_q;

   // Clear has priority over enable so a restart always begins at phase 00.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         gray_q <= 2'b00;
      end else if (en_i) begin
         gray_q <= gray2_next(gray_q);
      end
   end

   assign gray_o = gray_q;

endmodule

// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// Walks one kernel pass over a rows x cols tile, issuing SEQ_LEN table
// addresses per column, alternating the column parity select and stepping
// the row phase in Gray order. tbl_valid lines up with the table's
// registered output.
module cnn_layer_accel_weight_seq_ctrl
   import cnn_layer_accel_weight_seq_pkg::*;
#(
   parameter int SEQ_LEN     = SEQ_LEN_DEF,
   parameter int C_DIM_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [C_DIM_WIDTH-1:0] cfg_num_rows,
   input  logic [C_DIM_WIDTH-1:0] cfg_num_cols,
   input  logic                   stall,
   output logic [1:0]             gray_code,
   output logic                   sequence_selector,
   output logic [ADDR_W-1:0]      seq_data_addr,
   output logic                   seq_valid,
   output logic                   seq_last,
   output logic                   tbl_valid,
   output logic [C_DIM_WIDTH-1:0] row_idx,
   output logic [C_DIM_WIDTH-1:0] col_idx,
   output logic                   busy,
   output logic                   done
);

   logic [1:0]             state_q, state_d;
   logic [C_DIM_WIDTH-1:0] rows_q, cols_q;
   logic [C_DIM_WIDTH-1:0] row_q, col_q;
   logic [ADDR_W-1:0]      addr_q;
   logic                   sel_q;
   logic                   tbl_valid_q;

   logic start_acc;
   logic issue;
   logic last_addr, last_col, last_row;
   logic row_wrap;
   logic dims_zero;

   assign start_acc = (state_q == IDLE) && start;
   assign dims_zero = (cfg_num_rows == '0) || (cfg_num_cols == '0);
   assign issue     = (state_q == RUN) && !stall;

   // Latched dims are at least 1 whenever RUN is entered, so minus-one never underflows there.
   assign last_addr = (addr_q == ADDR_W'(SEQ_LEN - 1));
   assign last_col  = (col_q == cols_q - C_DIM_WIDTH'(1));
   assign last_row  = (row_q == rows_q - C_DIM_WIDTH'(1));
   assign row_wrap  = issue && last_addr && last_col;

   // Next-state selection for the pass FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = dims_zero ? DONE : RUN;
            end
         end
         RUN: begin
            if (row_wrap && last_row) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register and config capture; config is only sampled on an accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rows_q  <= '0;
         cols_q  <= '0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            rows_q <= cfg_num_rows;
            cols_q <= cfg_num_cols;
         end
      end
   end

   // Nested addr / column / row counters, advancing only on issue cycles.
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         addr_q <= '0;
         sel_q  <= 1'b1;
         col_q  <= '0;
         row_q  <= '0;
      end else if (issue) begin
         if (last_addr) begin
            addr_q <= '0;
            if (last_col) begin
               col_q <= '0;
               sel_q <= 1'b1;
               row_q <= row_q + C_DIM_WIDTH'(1);
            end else begin
               col_q <= col_q + C_DIM_WIDTH'(1);
               sel_q <= ~sel_q;
            end
         end else begin
            addr_q <= addr_q + ADDR_W'(1);
         end
      end
   end

   // Delay issue valid by one cycle to match the table's registered read.
   always_ff @(posedge clk) begin
      if (rst) begin
         tbl_valid_q <= 1'b0;
      end else begin
         tbl_valid_q <= issue;
      end
   end

   // Row phase steps once per completed row.
   cnn_layer_accel_gray_cnt2 u_gray (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (start_acc),
      .en_i   (row_wrap),
      .gray_o (gray_code)
   );

   assign sequence_selector = sel_q;
   assign seq_data_addr     = addr_q;
   assign seq_valid         = issue;
   assign seq_last          = row_wrap && last_row;
   assign tbl_valid         = tbl_valid_q;
   assign row_idx           = row_q;
   assign col_idx           = col_q;
   assign busy              = (state_q != IDLE);
   assign done              = (state_q == DONE);

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
// Scoreboard bench for the weight sequence sequencer: every expected issue
// is queued when a pass is started and popped as the DUT issues it.
module tb_cnn_layer_accel_weight_seq_ctrl;

   localparam int SEQ_LEN = 5;
   localparam int W       = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  cfg_num_rows;
   logic [W-1:0]  cfg_num_cols;
   logic          stall;
   logic [1:0]    gray_code;
   logic          sequence_selector;
   logic [2:0]    seq_data_addr;
   logic          seq_valid;
   logic          seq_last;
   logic          tbl_valid;
   logic [W-1:0]  row_idx;
   logic [W-1:0]  col_idx;
   logic          busy;
   logic          done;

   cnn_layer_accel_weight_seq_ctrl #(
      .SEQ_LEN     (SEQ_LEN),
      .C_DIM_WIDTH (W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .cfg_num_rows      (cfg_num_rows),
      .cfg_num_cols      (cfg_num_cols),
      .stall             (stall),
      .gray_code         (gray_code),
      .sequence_selector (sequence_selector),
      .seq_data_addr     (seq_data_addr),
      .seq_valid         (seq_valid),
      .seq_last          (seq_last),
      .tbl_valid         (tbl_valid),
      .row_idx           (row_idx),
      .col_idx           (col_idx),
      .busy              (busy),
      .done              (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {gray, sel, addr, row, col, last}
   typedef logic [38:0] exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_issues = 0;
   int last_cyc = -100;
   int done_cyc = -100;
   int done_cnt = 0;
   int t0       = 0;
   int base     = 0;
   logic mon_en  = 1'b0;
   logic prev_sv = 1'b0;
   logic prev_rst = 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [1:0] gray_of(input int r);
      logic [1:0] g;
      case (r % 4)
         0:       g = 2'b00;
         1:       g = 2'b01;
         2:       g = 2'b11;
         default: g = 2'b10;
      endcase
      return g;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops one expectation per issue and tracks tbl_valid/done timing.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("tbl_valid", {63'd0, tbl_valid}, {63'd0, prev_sv & ~prev_rst});
         if (seq_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_issue", 64'd1, 64'd0);
            end else begin
               automatic exp_t e = sb.pop_front();
               chk("issue", {25'd0, gray_code, sequence_selector, seq_data_addr,
                             row_idx, col_idx, seq_last}, {25'd0, e});
               n_issues++;
               $display("issue %0d: gray=%b sel=%0d addr=%0d row=%0d col=%0d last=%0d",
                        n_issues, gray_code, sequence_selector, seq_data_addr,
                        row_idx, col_idx, seq_last);
            end
            if (seq_last) last_cyc = cyc;
         end
         if (done) done_cnt++;
      end
      prev_sv  <= seq_valid;
      prev_rst <= rst;
   end

   // Drive a start pulse and queue the whole expected issue stream of the pass.
   task automatic do_start(input int rows, input int cols);
      @(posedge clk); #1;
      start        = 1'b1;
      cfg_num_rows = W'(rows);
      cfg_num_cols = W'(cols);
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++)
            for (int a = 0; a < SEQ_LEN; a++)
               sb.push_back({gray_of(r), (c % 2 == 0) ? 1'b1 : 1'b0, 3'(a), W'(r), W'(c),
                             (r == rows - 1 && c == cols - 1 && a == SEQ_LEN - 1) ? 1'b1 : 1'b0});
      @(posedge clk); #1;
      start = 1'b0;
      t0    = cyc;
      base  = n_issues;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            done_cyc = cyc;
            return;
         end
      end
      chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic finish_pass(input int exp_issues);
      chk("issue_count", 64'(n_issues - base), 64'(exp_issues));
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("done_after_last", 64'(done_cyc - last_cyc), 64'd1);
      @(negedge clk);
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("idle_after_done", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int dc0;
      rst          = 1'b1;
      start        = 1'b0;
      stall        = 1'b0;
      cfg_num_rows = '0;
      cfg_num_cols = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_gray", 64'(gray_code), 64'd0);
      chk("rst_sel", 64'(sequence_selector), 64'd1);
      chk("rst_addr", 64'(seq_data_addr), 64'd0);
      chk("rst_row", 64'(row_idx), 64'd0);
      chk("rst_col", 64'(col_idx), 64'd0);
      chk("rst_valid", 64'(seq_valid), 64'd0);
      chk("rst_last", 64'(seq_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);

      // 1 row x 2 cols: two columns of 5 with alternating select
      do_start(1, 2);
      wait_done(100);
      chk("done_time_1x2", 64'(done_cyc - t0), 64'd10);
      finish_pass(10);

      // 5 rows x 1 col: Gray phase wraps after 4 rows
      do_start(5, 1);
      wait_done(200);
      finish_pass(25);

      // 1x1 with 3 stall cycles at addr 2
      do_start(1, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", 64'(seq_valid), 64'd0);
         chk("stall_addr", 64'(seq_data_addr), 64'd2);
         if (i < 2) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      stall = 1'b0;
      wait_done(100);
      chk("done_time_stall", 64'(done_cyc - t0), 64'd8);
      finish_pass(5);

      // Zero columns: straight to DONE
      do_start(3, 0);
      @(negedge clk);
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd1);
      chk("zero_valid", 64'(seq_valid), 64'd0);
      @(negedge clk);
      chk("zero_done_end", 64'(done), 64'd0);
      chk("zero_busy_end", 64'(busy), 64'd0);

      // Start pulses during RUN and DONE are ignored
      do_start(2, 1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      start        = 1'b1;
      cfg_num_rows = 16'd7;
      cfg_num_cols = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      @(negedge clk);
      chk("done_with_start", 64'(done), 64'd1);
      done_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", 64'(busy), 64'd0);
      chk("issue_count_busy_start", 64'(n_issues - base), 64'd10);
      chk("sb_empty_busy_start", 64'(sb.size()), 64'd0);
      chk("done_after_last_busy", 64'(done_cyc - last_cyc), 64'd1);
      do_start(1, 1);
      wait_done(100);
      finish_pass(5);

      // Reset mid-pass
      do_start(2, 2);
      repeat (7) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      dc0 = done_cnt;
      @(negedge clk);
      chk("mid_rst_gray", 64'(gray_code), 64'd0);
      chk("mid_rst_sel", 64'(sequence_selector), 64'd1);
      chk("mid_rst_addr", 64'(seq_data_addr), 64'd0);
      chk("mid_rst_row", 64'(row_idx), 64'd0);
      chk("mid_rst_col", 64'(col_idx), 64'd0);
      chk("mid_rst_valid", 64'(seq_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      repeat (25) @(negedge clk);
      chk("mid_rst_no_done", 64'(done_cnt - dc0), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
